// File: rtl/nor3_stim_seq.sv
// Stimulus sequencer for a 3-input NOR cell: binary/Gray/LFSR vector passes with hold and repeat.
// Optional QN checker enabled by defining NOR3_CHECK_EN (adds QN, ERR, ERR_CNT ports).
module nor3_stim_seq #(
    parameter int         HOLD_W    = 8,
    parameter int         REP_W     = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [1:0]        MODE,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic [REP_W-1:0]  REPS,
`ifdef NOR3_CHECK_EN
    input  logic              QN,
    output logic              ERR,
    output logic [7:0]        ERR_CNT,
`endif
    output logic              IN1,
    output logic              IN2,
    output logic              IN3,
    output logic              VEC_VALID,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [HOLD_W-1:0] HOLD_ONE = 1;
    localparam logic [REP_W-1:0]  REP_ONE  = 1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [REP_W-1:0]  reps_q, reps_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [REP_W-1:0]  pcnt_q, pcnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        vec_q, vec_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              done_q, done_d;
    logic              hold_end;
    logic              accept;
    logic [7:0]        lfsr_nxt;

    // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [2:0] vec_sel(input logic [1:0] m, input logic [2:0] k,
                                           input logic [7:0] l);
        case (m)
            2'b01:   return k ^ (k >> 1);
            2'b10:   return l[2:0];
            default: return k;
        endcase
    endfunction

    assign hold_end = (hcnt_q == hold_q);
    assign accept   = (state_q == S_IDLE) && START && !ABORT;
    assign lfsr_nxt = lfsr_step(lfsr_q);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        reps_d  = reps_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        lfsr_d  = lfsr_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    mode_d  = MODE;
                    hold_d  = HOLD;
                    reps_d  = REPS;
                    hcnt_d  = '0;
                    pcnt_d  = '0;
                    idx_d   = '0;
                    vec_d   = vec_sel(MODE, 3'd0, lfsr_q);
                end
            end
            default: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                end else if (hold_end) begin
                    hcnt_d = '0;
                    idx_d  = idx_q + 3'd1;
                    // The LFSR only walks in LFSR mode and keeps its state across runs.
                    if (mode_q == 2'b10) lfsr_d = lfsr_nxt;
                    if (idx_q == 3'd7 && pcnt_q == reps_q) begin
                        state_d = S_IDLE;
                        vec_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        if (idx_q == 3'd7) pcnt_d = pcnt_q + REP_ONE;
                        vec_d = vec_sel(mode_q, idx_q + 3'd1, lfsr_nxt);
                    end
                end else begin
                    hcnt_d = hcnt_q + HOLD_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            idx_q   <= '0;
            vec_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            lfsr_q  <= lfsr_d;
            done_q  <= done_d;
        end
    end

    // Run configuration is only meaningful while BUSY, so it needs no reset.
    always_ff @(posedge CLK) begin
        mode_q <= mode_d;
        hold_q <= hold_d;
        reps_q <= reps_d;
    end

    assign IN1       = vec_q[0];
    assign IN2       = vec_q[1];
    assign IN3       = vec_q[2];
    assign BUSY      = (state_q == S_RUN);
    assign VEC_VALID = (state_q == S_RUN);
    assign DONE      = done_q;

`ifdef NOR3_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] ecnt_q, ecnt_d;

    // QN is judged on the final hold cycle, after the cell has had the longest time to settle.
    always_comb begin
        err_d  = err_q;
        ecnt_d = ecnt_q;
        if (accept) begin
            err_d  = 1'b0;
            ecnt_d = '0;
        end else if (state_q == S_RUN && hold_end && (QN != ~(|vec_q))) begin
            err_d = 1'b1;
            if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            err_q  <= err_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign ERR     = err_q;
    assign ERR_CNT = ecnt_q;
`endif

endmodule
